// File: rtl/fft_cbfp_pkg.sv
// Shared CBFP definitions: block shift-index width, unity-gain reference index,
// block FSM states and signed saturation bounds.
package fft_cbfp_pkg;

    localparam int CBFP_CNT_SIZE  = 5;
    localparam int CBFP_REF_SHIFT = 13;

    typedef enum logic {
        IDLE,
        BLK
    } state_e;

    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/cbfp_lane_shift.sv
// One signed lane of the CBFP denormalizer: shift by REF_SHIFT - exp, saturate.
// Define CBFP_DENORM_ROUND_EN for round-half-up on right shifts (else truncation).
module cbfp_lane_shift
    import fft_cbfp_pkg::*;
#(
    parameter int cnt_size  = CBFP_CNT_SIZE,
    parameter int din_size  = 12,
    parameter int dout_size = 16,
    parameter int REF_SHIFT = CBFP_REF_SHIFT
) (
    input  logic [cnt_size-1:0]         exp_i,
    input  logic signed [din_size-1:0]  din_i,
    output logic signed [dout_size-1:0] dout_o,
    output logic                        sat_o
);

    // Wide enough to hold the largest left shift without loss.
    localparam int WIDE = din_size + REF_SHIFT;

    logic signed [cnt_size:0] shift_s;
    logic signed [WIDE-1:0]   din_ext;
    logic signed [WIDE-1:0]   full;
`ifdef CBFP_DENORM_ROUND_EN
    logic signed [din_size:0] rnd_sum;
`endif
    int sh;
    int rs;

    assign shift_s = (cnt_size + 1)'(REF_SHIFT) - $signed({1'b0, exp_i});
    assign din_ext = {{(WIDE - din_size){din_i[din_size-1]}}, din_i};

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sh      = int'(shift_s);
        rs      = 0;
        full    = '0;
`ifdef CBFP_DENORM_ROUND_EN
        rnd_sum = '0;
`endif
        if (sh >= 0) begin
            full = din_ext <<< sh;
        end else begin
            rs = -sh;
`ifdef CBFP_DENORM_ROUND_EN
            // Beyond din_size+1 bits the half-LSB bias always dominates: result is 0.
            if (rs > din_size) begin
                full = '0;
            end else begin
                rnd_sum = {din_i[din_size-1], din_i} + ((din_size + 1)'(1) << (rs - 1));
                full    = WIDE'(rnd_sum >>> rs);
            end
`else
            if (rs >= din_size) begin
                full = {WIDE{din_i[din_size-1]}};
            end else begin
                full = WIDE'(din_i >>> rs);
            end
`endif
        end
    end

    always_comb begin
        sat_o  = 1'b0;
        dout_o = full[dout_size-1:0];
        if (longint'(full) > sat_max(dout_size)) begin
            sat_o  = 1'b1;
            dout_o = dout_size'(sat_max(dout_size));
        end else if (longint'(full) < sat_min(dout_size)) begin
            sat_o  = 1'b1;
            dout_o = dout_size'(sat_min(dout_size));
        end
    end

endmodule

// File: rtl/fft_cbfp_denorm.sv
// CBFP denormalizer at the FFT output: restores fixed-point scale per block of
// blk_beats beats with one output register stage. Optional CBFP_DENORM_ROUND_EN.
module fft_cbfp_denorm
    import fft_cbfp_pkg::*;
#(
    parameter int cnt_size   = CBFP_CNT_SIZE,
    parameter int din_size   = 12,
    parameter int dout_size  = 16,
    parameter int array_size = 8,
    parameter int blk_beats  = 4,
    parameter int REF_SHIFT  = CBFP_REF_SHIFT
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  clr,
    input  logic                                  valid_in,
    output logic                                  ready_in,
    input  logic [cnt_size-1:0]                   exp_in,
    input  logic [array_size-1:0][din_size-1:0]   din_re,
    input  logic [array_size-1:0][din_size-1:0]   din_im,
    output logic                                  valid_out,
    input  logic                                  ready_out,
    output logic [array_size-1:0][dout_size-1:0]  dout_re,
    output logic [array_size-1:0][dout_size-1:0]  dout_im,
    output logic                                  blk_last,
    output logic                                  sat_flag
);

    localparam int            CW        = $clog2(blk_beats);
    localparam logic [CW-1:0] LAST_BEAT = CW'(blk_beats - 1);

    state_e                               state_q, state_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [cnt_size-1:0]                  exp_q, exp_d;
    logic                                 valid_q, valid_d;
    logic                                 last_q, last_d;
    logic                                 sat_q, sat_d;
    logic [array_size-1:0][dout_size-1:0] dre_q, dre_d, dim_q, dim_d;

    logic [array_size-1:0][dout_size-1:0] res_re, res_im;
    logic [array_size-1:0]                sat_re, sat_im;
    logic [cnt_size-1:0]                  exp_use;
    logic                                 accept;

    assign ready_in = !clr && (!valid_q || ready_out);
    assign accept   = valid_in && ready_in;
    // The first beat of a block uses its own exponent; later beats the held one.
    assign exp_use  = (state_q == IDLE) ? exp_in : exp_q;

    for (genvar i = 0; i < array_size; i++) begin : g_lane
        cbfp_lane_shift #(
            .cnt_size (cnt_size),
            .din_size (din_size),
            .dout_size(dout_size),
            .REF_SHIFT(REF_SHIFT)
        ) u_re (
            .exp_i (exp_use),
            .din_i (din_re[i]),
            .dout_o(res_re[i]),
            .sat_o (sat_re[i])
        );

        cbfp_lane_shift #(
            .cnt_size (cnt_size),
            .din_size (din_size),
            .dout_size(dout_size),
            .REF_SHIFT(REF_SHIFT)
        ) u_im (
            .exp_i (exp_use),
            .din_i (din_im[i]),
            .dout_o(res_im[i]),
            .sat_o (sat_im[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        valid_d = valid_q;
        last_d  = last_q;
        sat_d   = sat_q;
        dre_d   = dre_q;
        dim_d   = dim_q;

        if (clr) begin
            // Abort wins over everything, including a same-cycle saturation.
            state_d = IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dre_d   = res_re;
            dim_d   = res_im;
            sat_d   = sat_q | (|sat_re) | (|sat_im);
            last_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    exp_d   = exp_in;
                    cnt_d   = CW'(1);
                    state_d = BLK;
                end
                BLK: begin
                    if (cnt_q == LAST_BEAT) begin
                        last_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else if (ready_out) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: data registers are reset as well so dout reads 0 straight out of reset.
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            dre_q   <= '0;
            dim_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            dre_q   <= dre_d;
            dim_q   <= dim_d;
        end
    end

    assign valid_out = valid_q;
    assign blk_last  = last_q;
    assign sat_flag  = sat_q;
    assign dout_re   = dre_q;
    assign dout_im   = dim_q;

endmodule

// File: tb/tb_fft_cbfp_denorm.sv
// Directed self-checking bench for fft_cbfp_denorm; expected values are hand-computed.
// Expected right-shift results follow CBFP_DENORM_ROUND_EN when it is defined.
module tb_fft_cbfp_denorm;

    localparam int LANES = 8;

    logic                   clk;
    logic                   rstn;
    logic                   clr;
    logic                   valid_in;
    logic                   ready_in;
    logic [4:0]             exp_in;
    logic [LANES-1:0][11:0] din_re;
    logic [LANES-1:0][11:0] din_im;
    logic                   valid_out;
    logic                   ready_out;
    logic [LANES-1:0][15:0] dout_re;
    logic [LANES-1:0][15:0] dout_im;
    logic                   blk_last;
    logic                   sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    fft_cbfp_denorm dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .exp_in   (exp_in),
        .din_re   (din_re),
        .din_im   (din_im),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .dout_re  (dout_re),
        .dout_im  (dout_im),
        .blk_last (blk_last),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] e, input int re, input int im);
        exp_in   = e;
        valid_in = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            din_re[i] = 12'(re);
            din_im[i] = 12'(im);
        end
    endtask

    task automatic check_out(input string tag, input int re, input int im, input logic last);
        check({tag, ".valid"}, valid_out, 1);
        check({tag, ".re0"}, $signed(dout_re[0]), re);
        check({tag, ".re7"}, $signed(dout_re[LANES-1]), re);
        check({tag, ".im0"}, $signed(dout_im[0]), im);
        check({tag, ".im7"}, $signed(dout_im[LANES-1]), im);
        check({tag, ".last"}, blk_last, last);
    endtask

    // Four beats; beat 0 carries e, the rest carry oe which must be ignored.
    task automatic run_block(input string tag, input logic [4:0] e, input logic [4:0] oe,
                             input int re, input int im, input int exp_re, input int exp_im);
        for (int b = 0; b < 4; b++) begin
            drive((b == 0) ? e : oe, re, im);
            @(negedge clk);
            check_out($sformatf("%s.b%0d", tag, b), exp_re, exp_im, b == 3);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        clr       = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        exp_in    = '0;
        din_re    = '0;
        din_im    = '0;

        repeat (2) @(negedge clk);
        check("rst.valid", valid_out, 0);
        check("rst.last", blk_last, 0);
        check("rst.sat", sat_flag, 0);
        check("rst.re0", $signed(dout_re[0]), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst.ready_in", ready_in, 1);

        // Unity gain.
        run_block("unity", 5'd13, 5'd13, -1000, 517, -1000, 517);
        @(negedge clk);
        check("unity.drop", valid_out, 0);
        check("unity.sat", sat_flag, 0);

        // Block exponent held: s=3.
        run_block("hold", 5'd10, 5'd31, 100, 100, 800, 800);
        check("hold.sat", sat_flag, 0);

        // Right shifts.
`ifdef CBFP_DENORM_ROUND_EN
        run_block("rsh3", 5'd16, 5'd0, -5, 5, -1, 1);
        run_block("rsh1", 5'd14, 5'd31, 3, -3, 2, -1);
        run_block("rsh18", 5'd31, 5'd0, -5, 5, 0, 0);
`else
        run_block("rsh3", 5'd16, 5'd0, -5, 5, -1, 0);
        run_block("rsh1", 5'd14, 5'd31, 3, -3, 1, -2);
        run_block("rsh18", 5'd31, 5'd0, -5, 5, -1, 0);
`endif
        check("rsh.sat", sat_flag, 0);

        // Saturation, then sticky flag across a clean block.
        run_block("sat", 5'd0, 5'd13, 2047, -2048, 32767, -32768);
        check("sat.flag", sat_flag, 1);
        run_block("sticky", 5'd13, 5'd13, 1, -1, 1, -1);
        check("sticky.flag", sat_flag, 1);

        // Backpressure mid-block.
        drive(5'd13, 11, -11);
        @(negedge clk);
        check_out("bp.b0", 11, -11, 1'b0);
        ready_out = 1'b0;
        drive(5'd0, 21, -21);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp.stall.ready_in", ready_in, 0);
            @(negedge clk);
            check_out($sformatf("bp.stall%0d", c), 11, -11, 1'b0);
        end
        ready_out = 1'b1;
        #1;
        check("bp.resume.ready_in", ready_in, 1);
        @(negedge clk);
        check_out("bp.b1", 21, -21, 1'b0);
        drive(5'd0, 31, -31);
        @(negedge clk);
        check_out("bp.b2", 31, -31, 1'b0);
        drive(5'd0, 41, -41);
        @(negedge clk);
        check_out("bp.b3", 41, -41, 1'b1);
        valid_in = 1'b0;

        // Abort after beat 1.
        drive(5'd13, 5, 5);
        @(negedge clk);
        drive(5'd13, 6, 6);
        @(negedge clk);
        check_out("abort.b1", 6, 6, 1'b0);
        check("abort.sat_before", sat_flag, 1);
        clr = 1'b1;
        drive(5'd12, 64, -64);
        #1;
        check("abort.ready_in", ready_in, 0);
        @(negedge clk);
        check("abort.valid", valid_out, 0);
        check("abort.sat", sat_flag, 0);
        clr = 1'b0;
        @(negedge clk);
        check_out("abort.n0", 128, -128, 1'b0);
        for (int b = 1; b < 4; b++) begin
            drive(5'd0, 64, -64);
            @(negedge clk);
            check_out($sformatf("abort.n%0d", b), 128, -128, b == 3);
        end
        valid_in = 1'b0;
        check("abort.sat_after", sat_flag, 0);

        // Async reset mid-block.
        drive(5'd13, 7, -7);
        @(negedge clk);
        check("arst.pre.valid", valid_out, 1);
        valid_in = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("arst.valid", valid_out, 0);
        check("arst.re0", $signed(dout_re[0]), 0);
        check("arst.last", blk_last, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_block("arst.blk", 5'd13, 5'd0, 9, -9, 9, -9);
        check("arst.sat", sat_flag, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
